// File: rtl/mem_initiator_if.sv
// +------------------------------------------------------------------+
// | Module   : mem_initiator_if                                      |
// | Purpose  : Core-side request/response channel and memory port    |
// |            bundle for mem_initiator.                             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  // core request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  // core response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  // memory port
  logic                  mem_enable;
  logic                  mem_write;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // initiator view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_enable, mem_write, mem_addr, mem_wdata
  );

  // core + memory view
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_enable, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_initiator.sv
// +------------------------------------------------------------------+
// | Module   : mem_initiator                                         |
// | Purpose  : Single-outstanding bus master for the enable/write/   |
// |            ready memory port, fed by a valid/ready core channel. |
// | Options  : MEM_INITIATOR_TIMEOUT_EN - abort a stalled access     |
// |            after TIMEOUT_CYCLES with an error response.          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module mem_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_SIZE      = 1024,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  mem_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(DATA_SIZE);

  // A zero timeout would make the counter compare meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("mem_initiator: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state, state_nxt;
  logic                  req_ready_nxt;
  logic                  rsp_valid_nxt;
  logic                  rsp_err_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_nxt;
  logic                  mem_enable_nxt;
  logic                  mem_write_nxt;
  logic [DATA_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic                  ready_seen;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]             timeout_cnt, timeout_cnt_nxt;
`endif

  // Only a clean 1 counts as ready; X/Z from an idle memory never completes an access.
  assign ready_seen = (bus.mem_ready === 1'b1);

  // Next-state and next-output decode; every output is held unless a transition changes it.
  always_comb begin
    state_nxt      = state;
    req_ready_nxt  = bus.req_ready;
    rsp_valid_nxt  = bus.rsp_valid;
    rsp_err_nxt    = bus.rsp_err;
    rsp_data_nxt   = bus.rsp_data;
    mem_enable_nxt = bus.mem_enable;
    mem_write_nxt  = bus.mem_write;
    mem_addr_nxt   = bus.mem_addr;
    mem_wdata_nxt  = bus.mem_wdata;
`ifdef MEM_INITIATOR_TIMEOUT_EN
    timeout_cnt_nxt = timeout_cnt;
`endif
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (bus.req_valid) begin
          req_ready_nxt = 1'b0;
          if (bus.req_addr >= ADDR_LIMIT) begin
            // Out-of-range: answer directly, memory stays untouched.
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
          end else begin
            state_nxt      = ACCESS;
            mem_enable_nxt = 1'b1;
            mem_write_nxt  = bus.req_write;
            mem_addr_nxt   = bus.req_addr;
            mem_wdata_nxt  = bus.req_wdata;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            timeout_cnt_nxt = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (ready_seen) begin
          // mem_write still reflects the request type during the access.
          rsp_data_nxt   = bus.mem_write ? '0 : bus.mem_rdata;
          mem_enable_nxt = 1'b0;
          mem_write_nxt  = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_err_nxt    = 1'b0;
          state_nxt      = RESP;
        end
`ifdef MEM_INITIATOR_TIMEOUT_EN
        else if (timeout_cnt == CNT_LAST) begin
          // Limit reached without ready: abandon the access.
          rsp_data_nxt    = '0;
          mem_enable_nxt  = 1'b0;
          mem_write_nxt   = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          timeout_cnt_nxt = timeout_cnt + 1'b1;
          state_nxt       = RESP;
        end else begin
          timeout_cnt_nxt = timeout_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = '0;
          req_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction at once.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_data   <= '0;
      bus.mem_enable <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      state          <= state_nxt;
      bus.req_ready  <= req_ready_nxt;
      bus.rsp_valid  <= rsp_valid_nxt;
      bus.rsp_err    <= rsp_err_nxt;
      bus.rsp_data   <= rsp_data_nxt;
      bus.mem_enable <= mem_enable_nxt;
      bus.mem_write  <= mem_write_nxt;
      bus.mem_addr   <= mem_addr_nxt;
      bus.mem_wdata  <= mem_wdata_nxt;
    end
  end

`ifdef MEM_INITIATOR_TIMEOUT_EN
  // Stall counter for the access in progress.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt_nxt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_initiator.sv
// +------------------------------------------------------------------+
// | Module   : tb_mem_initiator                                      |
// | Purpose  : Self-checking bench for mem_initiator with a          |
// |            behavioural memory and a response scoreboard.         |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_initiator;

  localparam int DW    = 32;
  localparam int DSIZE = 1024;
  localparam int TOUT  = 4;

  logic clk;
  logic rst_n;

  mem_initiator_if #(.DATA_WIDTH(DW)) bus ();

  mem_initiator #(
    .DATA_WIDTH    (DW),
    .DATA_SIZE     (DSIZE),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_seen = 0;
  int rsp_exp  = 0;
  int en_cycles = 0;
  int wr_cycles = 0;

  logic [DW:0] sb_q[$];   // {err, data}

  // Memory model: ready behaviour selected per test.
  // 0: ready whenever enabled, 1: never ready (floating), 2: ready on access cycle ready_at.
  int          ready_mode = 0;
  int          ready_at   = 1;
  int          en_cnt;
  logic [DW-1:0] mem [0:DSIZE-1];

  initial begin
    for (int i = 0; i < DSIZE; i++) mem[i] = '0;
    en_cnt = 0;
  end

  always @(posedge clk) en_cnt <= bus.mem_enable ? en_cnt + 1 : 0;

  always @(posedge clk)
    if (bus.mem_enable && bus.mem_write && bus.mem_ready === 1'b1 && bus.mem_addr < DSIZE)
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  assign bus.mem_ready = (ready_mode == 0) ? bus.mem_enable :
                         ((ready_mode == 2) && bus.mem_enable && (en_cnt == ready_at - 1)) ? 1'b1 : 1'bz;
  assign bus.mem_rdata = (bus.mem_enable && bus.mem_addr < DSIZE) ? mem[bus.mem_addr[9:0]] : 'z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: each new response is popped from the scoreboard once.
  initial begin
    logic        popped;
    logic [DW:0] e;
    popped = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_enable) en_cycles++;
      if (bus.mem_write)  wr_cycles++;
      if (bus.mem_write && !bus.mem_enable) check("write_without_enable", 1, 0);
      if (!rst_n) begin
        popped = 1'b0;
      end else if (bus.rsp_valid && !popped) begin
        popped = 1'b1;
        rsp_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_err", 64'(bus.rsp_err), 64'(e[DW]));
          check("rsp_data", 64'(bus.rsp_data), 64'(e[DW-1:0]));
        end
      end else if (!bus.rsp_valid) begin
        popped = 1'b0;
      end
    end
  end

  // Issue one request, record its expected response, and measure
  // the number of falling edges from acceptance until rsp_valid.
  task automatic do_req(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic exp_err, input logic [DW-1:0] exp_data, input int exp_lat);
    int k;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_req", 64'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    sb_q.push_back({exp_err, exp_data});
    rsp_exp++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("req_ready_after_accept", 64'(bus.req_ready), 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid && k < 40);
    check("rsp_latency", 64'(k), 64'(exp_lat));
  endtask

  // Let a response with rsp_ready high drain back to IDLE.
  task automatic drain;
    int k;
    k = 0;
    while (bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rsp_drained", 64'(bus.rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held_data;
    logic          held_err;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_req_ready", 64'(bus.req_ready), 1);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 0);
    check("reset_rsp_data", 64'(bus.rsp_data), 0);
    check("reset_mem_enable", 64'(bus.mem_enable), 0);
    check("reset_mem_addr", 64'(bus.mem_addr), 0);

    // Write 0x10 <- DEADBEEF, zero-wait memory.
    en_cycles = 0; wr_cycles = 0;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    drain();
    check("wr_enable_cycles", 64'(en_cycles), 1);
    check("wr_write_cycles", 64'(wr_cycles), 1);
    check("mem_word_10", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);

    // Read back 0x10.
    en_cycles = 0; wr_cycles = 0;
    do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    drain();
    check("rd_enable_cycles", 64'(en_cycles), 1);
    check("rd_write_cycles", 64'(wr_cycles), 0);

    // Out of range: 1024 is rejected without touching memory.
    en_cycles = 0;
    do_req(1'b0, 32'd1024, 32'h0, 1'b1, 32'h0, 1);
    drain();
    check("oor_enable_cycles", 64'(en_cycles), 0);
    en_cycles = 0;
    do_req(1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 32'h0, 1);
    drain();
    check("oor_max_enable_cycles", 64'(en_cycles), 0);

    // Last valid address.
    do_req(1'b1, 32'd1023, 32'hA5A5_0001, 1'b0, 32'h0, 2);
    drain();
    do_req(1'b0, 32'd1023, 32'h0, 1'b0, 32'hA5A5_0001, 2);
    drain();

    // Slow memory: ready on the third access cycle.
    ready_mode = 2; ready_at = 3;
    do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4);
    drain();
    ready_mode = 0;

    // Backpressure: response must hold for 5 cycles.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 32'd1023, 32'h0, 1'b0, 32'hA5A5_0001, 2);
    held_data = bus.rsp_data;
    held_err  = bus.rsp_err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 1);
      check("bp_rsp_data", 64'(bus.rsp_data), 64'(held_data));
      check("bp_rsp_err", 64'(bus.rsp_err), 64'(held_err));
      check("bp_req_ready", 64'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rsp_valid", 64'(bus.rsp_valid), 0);
    check("bp_release_req_ready", 64'(bus.req_ready), 1);
    check("bp_release_rsp_data", 64'(bus.rsp_data), 0);

`ifdef MEM_INITIATOR_TIMEOUT_EN
    // Floating ready: abort after TOUT access cycles.
    ready_mode = 1;
    do_req(1'b0, 32'h10, 32'h0, 1'b1, 32'h0, TOUT + 1);
    check("to_mem_enable", 64'(bus.mem_enable), 0);
    drain();
    // Ready on the final allowed cycle wins.
    ready_mode = 2; ready_at = TOUT;
    do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, TOUT + 1);
    drain();
    ready_mode = 0;
`endif

    // Reset during a stalled read: no response may follow.
    ready_mode = 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_enable_before", 64'(bus.mem_enable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable_async", 64'(bus.mem_enable), 0);
    @(negedge clk);
    ready_mode = 0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready), 1);
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 0);

    // Recovery after reset.
    do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    drain();
    repeat (2) @(negedge clk);

    check("sb_empty", 64'(sb_q.size()), 0);
    check("rsp_count", 64'(rsp_seen), 64'(rsp_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus master for the single-port memory block's enable/write/ready bus; the requesting side of that interface.
- Accepts one read or write request at a time from a core-side valid/ready channel.
- Drives the memory port, waits for ready, captures read data, and returns a response with an error flag.
- Sits between the CPU load/store path (or loader) and a memory instance.

Parameters:
- DATA_WIDTH, 32, width of address and data buses (matches memory).
- DATA_SIZE, 1024, number of words in the attached memory; bounds the address check.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without ready before an error response (used only with the optional feature).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- req_valid  input  1  core request valid.
- req_ready  output  1  initiator can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  DATA_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  core accepts response.
- rsp_data  output  DATA_WIDTH  read data (0 for writes and errors).
- rsp_err  output  1  1 = out-of-range address or timeout.
- mem_enable  output  1  memory enable.
- mem_write  output  1  memory write strobe.
- mem_ready  input  1  memory ready; may float when the memory is not enabled.
- mem_addr  output  DATA_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data; may float when the memory is not enabled.

Behaviour:
- Clock and reset: one clock, clk_in. rst_n_in is asynchronous and active-low.
- Reset values (asserted immediately on rst_n_in low, including mid-transaction):
  - state=IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - mem_enable=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Timeout counter=0.
  - An in-flight transaction is dropped with no response.
- Outputs are registered. Floating inputs are never propagated.
- mem_ready counts as asserted only when exactly 1'b1; X/Z count as not ready.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, latch req_write, req_addr and req_wdata, and set req_ready=0.
  - If req_addr >= DATA_SIZE: go to RESP with rsp_err=1 and rsp_data=0. The memory is never enabled.
  - Otherwise: go to ACCESS and drive mem_enable=1, mem_write=req_write, mem_addr=req_addr, mem_wdata=req_wdata.
- ACCESS:
  - Hold all mem_* outputs stable.
  - On an edge with mem_ready=1:
    - For a read, capture mem_rdata into rsp_data. For a write, rsp_data=0; the write commits at this same edge.
    - Drive mem_enable=0 and mem_write=0, set rsp_valid=1, rsp_err=0, and go to RESP.
  - mem_write is asserted only while mem_enable=1 and is never asserted for reads.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1 at an edge.
  - Then clear rsp_valid, rsp_err and rsp_data, set req_ready=1, and go to IDLE.
  - A new request cannot be accepted in the same cycle as a response handshake.
- Latency with a zero-wait memory:
  - Request accepted at edge N.
  - mem_enable high during cycle N to N+1; ready sampled at edge N+1.
  - rsp_valid high from edge N+1.
  - Throughput is at most one transaction per 3 cycles.
- Boundaries:
  - Address DATA_SIZE-1 is valid; DATA_SIZE is an error.
  - rsp_ready held high continuously means responses last exactly one cycle.
  - req_valid seen while req_ready=0 is ignored; the core must hold the request.

Optional Feature:
- Macro MEM_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter increments on each ACCESS cycle without mem_ready, and resets on entry to ACCESS.
  - When the counter reaches TIMEOUT_CYCLES without ready, deassert mem_enable and mem_write, set rsp_valid=1, rsp_err=1, rsp_data=0, and go to RESP.
  - If ready is sampled on the same edge that the limit is reached, ready wins: normal response.
- Undefined:
  - No counter is built.
  - ACCESS waits indefinitely for mem_ready.
  - rsp_err is set only for out-of-range addresses.

Test Plan:
- Write: addr 0x10, wdata 0xDEADBEEF, memory always ready.
  - mem_enable=1 and mem_write=1 for exactly one cycle.
  - rsp_valid one edge later, rsp_err=0.
  - Memory word 0x10 = 0xDEADBEEF.
- Read back: addr 0x10.
  - mem_write=0 throughout.
  - rsp_data=0xDEADBEEF with rsp_valid 1 edge after acceptance.
- Out of range: req_addr=1024 with DATA_SIZE=1024.
  - mem_enable never asserted.
  - rsp_valid with rsp_err=1, rsp_data=0.
  - Address 1023 completes normally.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_data and rsp_err stable, req_ready=0 throughout.
  - rsp_ready=1 returns to IDLE with req_ready=1 the next cycle.
- Stalled memory with MEM_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready=Z:
  - After 4 ACCESS cycles, mem_enable=0 and rsp_err=1.
  - Repeat with ready asserted on the 4th cycle: normal response, rsp_err=0.
- Reset mid-ACCESS: pull rst_n_in low during a read.
  - mem_enable drops immediately, without waiting for a clock edge.
  - After release: req_ready=1, rsp_valid=0, and no spurious response.
